// File: rtl/sprite_animator.sv
// Sprite engine for one character: stand/walk/hurt animation FSM, screen-to-ROM
// address generation with horizontal mirroring, a writable 16-entry palette and
// a fixed 3-cycle pixel pipeline (address -> ROM -> palette lookup).
module sprite_animator #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int FRAMES     = 5,
  parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H),
  parameter int TRANSP_IDX = 0,
  parameter int HURT_TICKS = 30,
  localparam int FI_W      = $clog2(FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              hflip,
  input  logic              walk,
  input  logic              hurt,
  input  logic [3:0]        anim_div,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  input  logic              pal_we,
  input  logic [3:0]        pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque,
  output logic [FI_W-1:0]   frame_idx,
  output logic [1:0]        state
);

  localparam int HC_W = $clog2(HURT_TICKS + 1);

  localparam logic [FI_W-1:0] FRAME_STAND      = FI_W'(0);
  localparam logic [FI_W-1:0] FRAME_FIRST_WALK = FI_W'(1);
  localparam logic [FI_W-1:0] FRAME_LAST_WALK  = FI_W'(FRAMES - 2);
  localparam logic [FI_W-1:0] FRAME_HURT       = FI_W'(FRAMES - 1);
  localparam logic [HC_W-1:0] HURT_LAST        = HC_W'(HURT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_STAND = 2'b00,
    ST_WALK  = 2'b01,
    ST_HURT  = 2'b10
  } state_t;

  state_t            state_r;
  logic [FI_W-1:0]   frame_idx_r;
  logic [3:0]        tick_cnt_r;
  logic [HC_W-1:0]   hurt_cnt_r;
  logic [9:0]        sx_r;
  logic [9:0]        sy_r;
  logic              hflip_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              in_box_d1_r;
  logic              in_box_d2_r;
  logic [11:0]       rgb_r;
  logic              opaque_r;
  logic [11:0]       pal_r [16];

  logic [3:0]        div_last_s;
  logic [9:0]        col_s;
  logic [9:0]        row_s;
  logic [9:0]        colp_s;
  logic              in_box_s;
  logic [ADDR_W-1:0] addr_s;

  // Walk cycle runs over frames 1..FRAMES-2 and then wraps back to frame 1.
  function automatic logic [FI_W-1:0] next_walk_frame(input logic [FI_W-1:0] f);
    if (f == FRAME_LAST_WALK) begin
      return FRAME_FIRST_WALK;
    end else begin
      return f + FI_W'(1);
    end
  endfunction

  // Last walk-tick count before a frame advance; a divider of 0 acts as 1.
  always_comb begin
    div_last_s = 4'd0;
    if (anim_div == 4'd0) begin
      div_last_s = 4'd0;
    end else begin
      div_last_s = anim_div - 4'd1;
    end
  end

  // Animation FSM: hurt pre-empts everything, other moves happen on frame ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_STAND;
      frame_idx_r <= FRAME_STAND;
      tick_cnt_r  <= 4'd0;
      hurt_cnt_r  <= '0;
    end else if (hurt) begin
      state_r     <= ST_HURT;
      frame_idx_r <= FRAME_HURT;
      hurt_cnt_r  <= '0;
    end else if (frame_tick) begin
      case (state_r)
        ST_STAND: begin
          if (walk) begin
            state_r     <= ST_WALK;
            frame_idx_r <= FRAME_FIRST_WALK;
            tick_cnt_r  <= 4'd0;
          end else begin
            frame_idx_r <= FRAME_STAND;
          end
        end
        ST_WALK: begin
          if (!walk) begin
            state_r     <= ST_STAND;
            frame_idx_r <= FRAME_STAND;
          end else if (tick_cnt_r >= div_last_s) begin
            tick_cnt_r  <= 4'd0;
            frame_idx_r <= next_walk_frame(frame_idx_r);
          end else begin
            tick_cnt_r  <= tick_cnt_r + 4'd1;
          end
        end
        ST_HURT: begin
          if (hurt_cnt_r == HURT_LAST) begin
            tick_cnt_r <= 4'd0;
            if (walk) begin
              state_r     <= ST_WALK;
              frame_idx_r <= FRAME_FIRST_WALK;
            end else begin
              state_r     <= ST_STAND;
              frame_idx_r <= FRAME_STAND;
            end
          end else begin
            hurt_cnt_r <= hurt_cnt_r + HC_W'(1);
          end
        end
        default: begin
          state_r     <= ST_STAND;
          frame_idx_r <= FRAME_STAND;
        end
      endcase
    end
  end

  // Shadow position/flip so the sprite cannot tear within a video frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_r    <= 10'd0;
      sy_r    <= 10'd0;
      hflip_r <= 1'b0;
    end else if (frame_tick) begin
      sx_r    <= SpriteX;
      sy_r    <= SpriteY;
      hflip_r <= hflip;
    end
  end

  // Box test and ROM address; negative offsets wrap to large values and fail.
  always_comb begin
    col_s    = DrawX - sx_r;
    row_s    = DrawY - sy_r;
    in_box_s = ({1'b0, col_s} < 11'(SPR_W)) && ({1'b0, row_s} < 11'(SPR_H));
    colp_s   = col_s;
    if (hflip_r) begin
      colp_s = 10'(SPR_W - 1) - col_s;
    end else begin
      colp_s = col_s;
    end
    addr_s = ADDR_W'(32'(frame_idx_r) * 32'(SPR_W * SPR_H)
                   + 32'(row_s) * 32'(SPR_W) + 32'(colp_s));
  end

  // Address stage and box-flag delay line matching the ROM latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_r  <= '0;
      in_box_d1_r <= 1'b0;
      in_box_d2_r <= 1'b0;
    end else begin
      rom_addr_r  <= in_box_s ? addr_s : '0;
      in_box_d1_r <= in_box_s;
      in_box_d2_r <= in_box_d1_r;
    end
  end

  // Palette register file; a same-cycle read sees the value before the write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        pal_r[i] <= 12'h000;
      end
    end else if (pal_we) begin
      pal_r[pal_waddr] <= pal_wdata;
    end
  end

  // Output stage: palette lookup, blanked outside the sprite box.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_r    <= 12'h000;
      opaque_r <= 1'b0;
    end else if (in_box_d2_r) begin
      rgb_r    <= pal_r[rom_q];
      opaque_r <= (rom_q != 4'(TRANSP_IDX));
    end else begin
      rgb_r    <= 12'h000;
      opaque_r <= 1'b0;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign red       = rgb_r[11:8];
  assign green     = rgb_r[7:4];
  assign blue      = rgb_r[3:0];
  assign opaque    = opaque_r;
  assign frame_idx = frame_idx_r;
  assign state     = state_r;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed and randomized bench for sprite_animator with a tick-count based
// animation model, a synchronous ROM model and a palette shadow.
module tb_sprite_animator;

  localparam int SPR_W = 64;
  localparam int SPR_H = 64;
  localparam int FRAMES = 5;
  localparam int ADDR_W = 15;
  localparam int HURT_TICKS = 30;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_tick = 1'b0;
  logic [9:0] DrawX = 10'd0, DrawY = 10'd0, SpriteX = 10'd0, SpriteY = 10'd0;
  logic hflip = 1'b0, walk = 1'b0, hurt = 1'b0;
  logic [3:0] anim_div = 4'd1;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0] rom_q = 4'd0;
  logic pal_we = 1'b0;
  logic [3:0] pal_waddr = 4'd0;
  logic [11:0] pal_wdata = 12'h000;
  logic [3:0] red, green, blue;
  logic opaque;
  logic [2:0] frame_idx;
  logic [1:0] state;

  int vec = 0;
  int errs = 0;

  logic [3:0] rom_mem [1 << ADDR_W];
  logic [11:0] m_pal [16];
  int m_mode, m_walk_n, m_hurt_n;
  logic [9:0] m_sx, m_sy;
  logic m_hf;

  sprite_animator dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .hflip(hflip), .walk(walk), .hurt(hurt), .anim_div(anim_div),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .red(red), .green(green), .blue(blue), .opaque(opaque),
    .frame_idx(frame_idx), .state(state)
  );

  always #5 Clk = ~Clk;

  // External synchronous ROM: data one cycle after the address.
  always @(posedge Clk) rom_q <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_frame();
    int div;
    div = (anim_div == 4'd0) ? 1 : int'(anim_div);
    if (m_mode == 0) return 0;
    if (m_mode == 2) return FRAMES - 1;
    return 1 + ((m_walk_n / div) % (FRAMES - 2));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_walk_n = 0; m_hurt_n = 0;
    m_sx = 10'd0; m_sy = 10'd0; m_hf = 1'b0;
    for (int i = 0; i < 16; i++) m_pal[i] = 12'h000;
  endtask

  // One clock with the given hurt/frame_tick, then check state and frame.
  task automatic step(input bit h, input bit t);
    hurt = h; frame_tick = t;
    @(posedge Clk);
    if (t) begin m_sx = SpriteX; m_sy = SpriteY; m_hf = hflip; end
    if (h) begin
      m_mode = 2; m_hurt_n = 0;
    end else if (t) begin
      case (m_mode)
        0: if (walk) begin m_mode = 1; m_walk_n = 0; end
        1: if (!walk) m_mode = 0; else m_walk_n++;
        default: begin
          m_hurt_n++;
          if (m_hurt_n == HURT_TICKS) begin m_mode = walk ? 1 : 0; m_walk_n = 0; end
        end
      endcase
    end
    #1;
    hurt = 1'b0; frame_tick = 1'b0;
    chk("state", 32'(state), 32'(m_mode));
    chk("frame_idx", 32'(frame_idx), 32'(m_frame()));
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
    pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
    @(posedge Clk); #1;
    pal_we = 1'b0;
    m_pal[a] = d;
  endtask

  // Present one pixel and check address at N+1 and colour at N+3.
  task automatic pix(input logic [9:0] dx, input logic [9:0] dy);
    int c, r, cc, a, idx;
    bit inb;
    DrawX = dx; DrawY = dy;
    c = (int'(dx) - int'(m_sx)) & 1023;
    r = (int'(dy) - int'(m_sy)) & 1023;
    inb = (c < SPR_W) && (r < SPR_H);
    cc = m_hf ? (SPR_W - 1 - c) : c;
    a = inb ? ((m_frame() * SPR_W * SPR_H + r * SPR_W + cc) % (1 << ADDR_W)) : 0;
    idx = int'(rom_mem[a]);
    @(posedge Clk); #1;
    chk("rom_addr", 32'(rom_addr), 32'(a));
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rgb", {20'd0, red, green, blue}, inb ? {20'd0, m_pal[idx]} : 32'd0);
    chk("opaque", 32'(opaque), 32'(inb && idx != 0));
  endtask

  initial begin
    int seq3 [9] = '{1, 1, 2, 2, 3, 3, 1, 1, 2};
    int seq5 [4] = '{1, 2, 3, 1};
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 4'($urandom_range(1, 15));
    rom_mem[0] = 4'd3;
    rom_mem[1] = 4'd0;
    rom_mem[2] = 4'd5;
    model_reset();

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    chk("rst_opaque", 32'(opaque), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_frame", 32'(frame_idx), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Basic pixel: palette[3]=F80 at sprite origin
    pal_write(4'd3, 12'hF80);
    SpriteX = 10'd100; SpriteY = 10'd50;
    step(1'b0, 1'b1);
    pix(10'd100, 10'd50);
    chk("t1_red", 32'(red), 32'hF);
    chk("t1_green", 32'(green), 32'h8);
    // Transparent index inside box
    pix(10'd101, 10'd50);
    // Position change without frame_tick must not move the sprite
    SpriteX = 10'd300;
    pix(10'd100, 10'd50);
    SpriteX = 10'd100;

    // Horizontal flip and left-edge box boundary
    hflip = 1'b1;
    step(1'b0, 1'b1);
    pix(10'd100, 10'd51);
    chk("t2_flip_addr", 32'(rom_addr), 32'd127);
    pix(10'd99, 10'd51);
    pix(10'd163, 10'd113);
    pix(10'd164, 10'd60);
    hflip = 1'b0;
    step(1'b0, 1'b1);

    // Walk cycle with anim_div=2
    anim_div = 4'd2; walk = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1);
      chk("t3_seq", 32'(frame_idx), 32'(seq3[i]));
    end
    walk = 1'b0;
    step(1'b0, 1'b1);
    chk("t3_stand", 32'(frame_idx), 32'd0);

    // Hurt coincident with frame_tick, then timeout back to walk
    walk = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t4_hurt_frame", 32'(frame_idx), 32'd4);
    for (int i = 0; i < HURT_TICKS; i++) step(1'b0, 1'b1);
    chk("t4_exit_state", 32'(state), 32'd1);
    chk("t4_exit_frame", 32'(frame_idx), 32'd1);
    // Re-hurt at tick 15 restarts the hurt counter
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < HURT_TICKS - 1; i++) step(1'b0, 1'b1);
    chk("t4_still_hurt", 32'(state), 32'd2);
    step(1'b0, 1'b1);
    chk("t4_exit2", 32'(frame_idx), 32'd1);

    // anim_div=0 acts as 1
    walk = 1'b0;
    step(1'b0, 1'b1);
    anim_div = 4'd0; walk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      chk("t5_div0", 32'(frame_idx), 32'(seq5[i]));
    end
    walk = 1'b0;
    step(1'b0, 1'b1);

    // Palette write while the same entry is being read
    pal_write(4'd5, 12'hABC);
    DrawX = 10'd102; DrawY = 10'd50;
    repeat (3) @(posedge Clk);
    #1;
    chk("pal_before", {20'd0, red, green, blue}, 32'hABC);
    pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 12'h123;
    @(posedge Clk); #1;
    pal_we = 1'b0; m_pal[5] = 12'h123;
    chk("pal_old_on_write", {20'd0, red, green, blue}, 32'hABC);
    @(posedge Clk); #1;
    chk("pal_new", {20'd0, red, green, blue}, 32'h123);

    // Randomized animation traffic
    anim_div = 4'($urandom_range(0, 4));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) walk = ~walk;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
    end

    // Randomized pixels with random palette, position and flip
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) pal_write(4'($urandom_range(0, 15)), 12'($urandom));
      SpriteX = 10'($urandom); SpriteY = 10'($urandom); hflip = 1'($urandom);
      step(1'b0, 1'b1);
      pix(10'(int'(SpriteX) + $urandom_range(0, 80) - 8),
          10'(int'(SpriteY) + $urandom_range(0, 80) - 8));
    end

    // Asynchronous reset mid-line while in HURT
    walk = 1'b1;
    SpriteX = 10'd200; SpriteY = 10'd100;
    step(1'b1, 1'b1);
    DrawX = 10'd210; DrawY = 10'd110;
    repeat (3) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    chk("arst_rgb", {20'd0, red, green, blue}, 32'd0);
    chk("arst_opaque", 32'(opaque), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_frame", 32'(frame_idx), 32'd0);
    model_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    walk = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_state", 32'(state), 32'd0);
    pix(10'd5, 10'd5);
    pix(10'd0, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview: Parametrised sprite engine that replaces the per-frame ROM/palette wrappers with a single block per character. It owns the animation state machine (stand, walk cycle, hurt) and the screen-to-ROM address generation. It also holds a writable 16-entry palette register file and drives a pipelined RGB/opaque pixel into the colour mapper. All frames live in one external synchronous ROM, stored frame-major.

Parameters:
SPR_W, 64, sprite width in pixels
SPR_H, 64, sprite height in pixels
FRAMES, 5, frames in ROM; frame 0 = stand, 1..FRAMES-2 = walk cycle, FRAMES-1 = hurt
ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width
TRANSP_IDX, 0, palette index treated as transparent
HURT_TICKS, 30, frame ticks spent in HURT

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
SpriteX  in  10  sprite top-left column
SpriteY  in  10  sprite top-left row
hflip  in  1  mirror horizontally (facing left)
walk  in  1  1 = walking, 0 = standing
hurt  in  1  pulse: enter HURT
anim_div  in  4  frame ticks per walk frame; 0 treated as 1
rom_addr  out  ADDR_W  registered address to external ROM
rom_q  in  4  ROM palette index, valid one cycle after rom_addr
pal_we  in  1  palette write enable
pal_waddr  in  4  palette entry
pal_wdata  in  12  {R,G,B} 4 bits each
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
opaque  out  1  pixel inside sprite box and index != TRANSP_IDX
frame_idx  out  $clog2(FRAMES)  frame currently displayed
state  out  2  00 STAND, 01 WALK, 10 HURT

Behaviour:
- Reset (async, Reset_n=0): state=STAND, frame_idx=0, tick counter=0, rom_addr=0, red/green/blue=0, opaque=0, all palette entries=0, latched position/flip=0.
- Frame latch: on frame_tick, SpriteX, SpriteY and hflip are captured into shadow registers. Address generation uses only the shadow values, so a sprite never tears mid-frame.
- FSM, evaluated on frame_tick cycles only, except hurt:
  - hurt=1 on any cycle -> HURT, frame_idx=FRAMES-1, hurt counter=0. hurt while already in HURT restarts the counter.
  - STAND: walk=1 -> WALK with frame_idx=1 and tick counter=0. Otherwise frame_idx stays 0.
  - WALK: walk=0 -> STAND, frame_idx=0. Otherwise the tick counter increments. When it reaches max(anim_div,1)-1 it clears and frame_idx advances; frame FRAMES-2 wraps to 1.
  - HURT: the hurt counter increments each frame_tick. On reaching HURT_TICKS-1 the block goes to WALK (frame 1) if walk=1, else STAND (frame 0).
  - hurt and frame_tick in the same cycle: hurt wins, and the counter starts at 0.
- Address stage (cycle N -> N+1):
  - col = DrawX-SpriteX_s, row = DrawY-SpriteY_s, as unsigned 10-bit differences.
  - in_box = col<SPR_W and row<SPR_H. Wrap-around makes negative offsets large, so they fail the compare.
  - col' = hflip_s ? SPR_W-1-col : col.
  - rom_addr <= frame_idx*SPR_W*SPR_H + row*SPR_W + col', truncated to ADDR_W.
  - When in_box=0, rom_addr <= 0.
  - in_box is delayed alongside the address.
- ROM stage (N+1 -> N+2): rom_q is valid; in_box is delayed one more cycle.
- Output stage (N+2 -> N+3): {red,green,blue} <= palette[rom_q]; opaque <= in_box_d2 && rom_q!=TRANSP_IDX.
  - When in_box_d2=0, RGB=0 and opaque=0.
  - Total latency DrawX/DrawY -> RGB is 3 cycles, fixed.
- Palette: a write takes effect on the next edge. A read of the same entry in the same cycle returns the old value. Writes are allowed at any time.
- frame_idx changes only at frame_tick or hurt. A hurt pulse mid-line therefore switches frames mid-frame, which is accepted (hurt flash).

Test Plan:
1. Reset release, palette[3]=12'hF80, SpriteX=100, SpriteY=50, frame_tick, DrawX=100, DrawY=50, ROM returns 3 -> rom_addr=0 at N+1; RGB=F,8,0 and opaque=1 at N+3.
2. hflip=1 latched, DrawX=100, DrawY=51 -> rom_addr=SPR_W+63=127 (frame 0). DrawX=99 -> in_box=0, opaque=0, rom_addr=0.
3. walk=1, anim_div=2, FRAMES=5, 9 frame_ticks -> frame_idx sequence 1,1,2,2,3,3,1,1,2 (wrap 3->1); walk=0 at next tick -> STAND, frame 0.
4. hurt pulse coincident with frame_tick in WALK -> frame_idx=4, state=HURT. After 30 ticks with walk=1 -> WALK, frame 1. Second hurt at tick 15 -> stays HURT 30 more ticks.
5. ROM returns TRANSP_IDX=0 inside box -> opaque=0. anim_div=0 behaves as 1 (frame advances every tick).
6. Reset_n asserted mid-line while in HURT -> outputs 0 immediately (asynchronous), palette cleared, state=STAND after release.
